// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch (IF) and data access (MEM).
// Optional IF anti-starvation counter is enabled by defining MEM_ARB_FAIRNESS_EN.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_valid,
  output logic              i_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              d_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D} state_t;

  state_t            state, state_nxt;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              grant_d, grant_i;

`ifdef MEM_ARB_FAIRNESS_EN
  localparam int unsigned CNT_W = ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3;

  logic [CNT_W-1:0] starve_cnt;
  logic             if_turn;

  assign if_turn = (starve_cnt == CNT_W'(STARVE_LIMIT));
  assign grant_d = (state == IDLE) && d_req && !(i_req && if_turn);
  assign grant_i = (state == IDLE) && i_req && !grant_d;

  // Counts data grants that overtook a waiting fetch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (grant_i) begin
      starve_cnt <= '0;
    end else if (grant_d && i_req) begin
      starve_cnt <= starve_cnt + 1'b1;
    end else if (state == IDLE && !i_req) begin
      starve_cnt <= '0;
    end
  end
`else
  assign grant_d = (state == IDLE) && d_req;
  assign grant_i = (state == IDLE) && i_req && !d_req;

  // The starvation limit is only consumed by the fairness build.
  if (STARVE_LIMIT == 0) begin : g_no_fairness
  end
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (grant_d)      state_nxt = BUSY_D;
        else if (grant_i) state_nxt = BUSY_I;
      end
      BUSY_I:  if (mem_ack) state_nxt = DONE_I;
      BUSY_D:  if (mem_ack) state_nxt = DONE_D;
      DONE_I:  state_nxt = IDLE;
      DONE_D:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      state <= state_nxt;
      if (grant_d) begin
        lat_we    <= d_we;
        lat_addr  <= d_addr;
        lat_wdata <= d_wdata;
      end else if (grant_i) begin
        lat_we   <= 1'b0;
        lat_addr <= i_addr;
      end
      if (state == BUSY_I && mem_ack) i_rdata <= mem_rdata;
      // Stores leave the previous load data visible on d_rdata.
      if (state == BUSY_D && mem_ack && !lat_we) d_rdata <= mem_rdata;
    end
  end

  assign mem_req   = (state == BUSY_I) || (state == BUSY_D);
  assign mem_we    = (state == BUSY_D) && lat_we;
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;
  assign i_valid   = (state == DONE_I);
  assign d_valid   = (state == DONE_D);
  assign i_stall   = i_req & ~i_valid;
  assign d_stall   = d_req & ~d_valid;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios plus random IF/MEM traffic
// against a variable-latency memory model; honours MEM_ARB_FAIRNESS_EN when defined.
module tb_mem_port_arbiter;
  localparam int SL = 4;

  logic        clk, reset;
  logic        i_req;
  logic [31:0] i_addr, i_rdata;
  logic        i_valid, i_stall;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        d_valid, d_stall;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        busy;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid), .i_stall(i_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
    .d_valid(d_valid), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] i_exp[$];
  logic [31:0] d_exp[$];
  bit          win_q[$];            // 1 = data port expected to win that grant
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] resp_mem[logic [31:0]];
  logic [31:0] last_d_rd = '0;
  int          fixed_wait = -1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, ~a[15:0]};
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_word(a);
  endfunction

  function automatic logic [31:0] resp_rd(input logic [31:0] a);
    if (resp_mem.exists(a)) return resp_mem[a];
    return init_word(a);
  endfunction

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void chk1(input string name, input logic act, input logic exp);
    check(name, 32'(act), 32'(exp));
  endfunction

  function automatic void report(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: got event, expected none at %0t", name, $time);
  endfunction

  function automatic bit exp_grant_d(input int n);
`ifdef MEM_ARB_FAIRNESS_EN
    return (n % (SL + 1)) != SL;
`else
    return (n >= 0);
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory model: acknowledges after a chosen number of wait cycles.
  initial begin
    bit active;
    int wcnt;
    active = 0;
    wcnt = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (!reset) begin
        mem_ack = 1'b0;
        active = 0;
      end else if (mem_ack) begin
        mem_ack = 1'b0;
        active = 0;
      end else if (mem_req) begin
        if (!active) begin
          active = 1;
          wcnt = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(3, 0));
        end
        if (wcnt == 0) begin
          mem_ack = 1'b1;
          if (mem_we) begin
            resp_mem[mem_addr] = mem_wdata;
            mem_rdata = $urandom;
          end else begin
            mem_rdata = resp_rd(mem_addr);
          end
        end else begin
          wcnt--;
        end
      end else begin
        active = 0;
      end
    end
  end

  // Monitor: compares every completion against the scoreboard.
  logic prev_ack = 0, prev_mreq = 0, prev_ireq = 0, prev_dreq = 0;
`ifdef MEM_ARB_FAIRNESS_EN
  int streak = 0;
`endif

  always @(negedge clk) begin
    bit win_d;
    if (!reset) begin
      prev_ack = 0; prev_mreq = 0; prev_ireq = 0; prev_dreq = 0;
      win_q.delete();
`ifdef MEM_ARB_FAIRNESS_EN
      streak = 0;
`endif
    end else begin
      chk1("i_stall", i_stall, i_req & ~i_valid);
      chk1("d_stall", d_stall, d_req & ~d_valid);
      chk1("valid_after_ack", i_valid | d_valid, prev_ack & prev_mreq);
      if (i_valid && d_valid) report("both_valid");
`ifdef MEM_ARB_FAIRNESS_EN
      if (!mem_req && !i_valid && !d_valid && !i_req) streak = 0;
`endif
      if (mem_req && !prev_mreq) begin
        if (!prev_ireq && !prev_dreq) begin
          report("spurious_grant");
        end else begin
          win_d = prev_dreq;
`ifdef MEM_ARB_FAIRNESS_EN
          if (prev_dreq && prev_ireq && streak == SL) win_d = 0;
          if (win_d && prev_ireq) streak++;
          else if (!win_d) streak = 0;
`endif
          win_q.push_back(win_d);
          if (!win_d) chk1("mem_we_fetch", mem_we, 1'b0);
        end
      end
      if (i_valid || d_valid) begin
        if (win_q.size() == 0) report("valid_without_grant");
        else chk1("grant_port", d_valid, win_q.pop_front());
      end
      if (i_valid) begin
        if (i_exp.size() == 0) report("i_valid_unexpected");
        else check("i_rdata", i_rdata, i_exp.pop_front());
      end
      if (d_valid) begin
        if (d_exp.size() == 0) report("d_valid_unexpected");
        else check("d_rdata", d_rdata, d_exp.pop_front());
      end
      prev_ack = mem_ack; prev_mreq = mem_req; prev_ireq = i_req; prev_dreq = d_req;
    end
  end

  task automatic wait_valid(input bit is_d, output bit ok);
    ok = 0;
    for (int n = 0; n < 100; n++) begin
      tick();
      if (is_d ? d_valid : i_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) report(is_d ? "d_timeout" : "i_timeout");
  endtask

  task automatic if_driver(input int n);
    bit ok;
    int gap;
    logic [31:0] a;
    for (int t = 0; t < n; t++) begin
      gap = $urandom_range(3, 0);
      if (gap > 0) begin
        i_req = 1'b0;
        repeat (gap) tick();
      end
      a = {26'b0, 4'($urandom), 2'b0};
      i_addr = a;
      i_req = 1'b1;
      i_exp.push_back(ref_rd(a));
      wait_valid(1'b0, ok);
      if (!ok) break;
    end
    i_req = 1'b0;
  endtask

  task automatic d_driver(input int n);
    bit ok;
    int gap;
    logic [31:0] a, v;
    for (int t = 0; t < n; t++) begin
      gap = $urandom_range(3, 0);
      if (gap > 0) begin
        d_req = 1'b0;
        repeat (gap) tick();
      end
      a = 32'h200 + {26'b0, 4'($urandom), 2'b0};
      d_addr = a;
      d_we = 1'($urandom);
      if (d_we) begin
        v = $urandom;
        d_wdata = v;
        ref_mem[a] = v;
        d_exp.push_back(last_d_rd);
      end else begin
        d_wdata = $urandom;
        v = ref_rd(a);
        d_exp.push_back(v);
        last_d_rd = v;
      end
      d_req = 1'b1;
      wait_valid(1'b1, ok);
      if (!ok) break;
    end
    d_req = 1'b0;
  endtask

  initial begin
    bit ok, is_d, keep;
    int grants, tmo;
    reset = 1'b0;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    tick();
    tick();
    chk1("rst_mem_req", mem_req, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, '0);
    check("rst_mem_wdata", mem_wdata, '0);
    chk1("rst_valids", i_valid | d_valid, 1'b0);
    check("rst_i_rdata", i_rdata, '0);
    check("rst_d_rdata", d_rdata, '0);
    chk1("rst_busy", busy, 1'b0);
    reset = 1'b1;
    tick();

    // Single fetch with three memory wait cycles.
    fixed_wait = 3;
    resp_mem[32'h10] = 32'hDEADBEEF;
    ref_mem[32'h10] = 32'hDEADBEEF;
    tick();
    i_req = 1'b1; i_addr = 32'h10;
    i_exp.push_back(ref_rd(32'h10));
    for (int c = 0; c <= 5; c++) begin
      if (c > 0) tick();
      chk1("t1_mem_req", mem_req, (c >= 1 && c <= 4));
      chk1("t1_i_valid", i_valid, (c == 5));
      if (i_valid) i_req = 1'b0;
    end
    check("t1_i_rdata", i_rdata, 32'hDEADBEEF);

    // Simultaneous requests, zero-wait memory: data first.
    fixed_wait = 0;
    tick();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    i_req = 1'b1; i_addr = 32'h20;
    last_d_rd = ref_rd(32'h100);
    d_exp.push_back(last_d_rd);
    i_exp.push_back(ref_rd(32'h20));
    for (int c = 0; c <= 5; c++) begin
      if (c > 0) tick();
      if (d_valid) d_req = 1'b0;
      if (i_valid) i_req = 1'b0;
      #1;
      chk1("t2_i_stall", i_stall, (c <= 4));
      chk1("t2_d_valid", d_valid, (c == 2));
      chk1("t2_i_valid", i_valid, (c == 5));
      if (c == 1) chk1("t2_busy", busy, 1'b1);
      if (c == 4) begin
        check("t2_mem_addr", mem_addr, 32'h20);
        chk1("t2_mem_req", mem_req, 1'b1);
      end
    end

    // Store whose inputs change while the transaction is in flight.
    tick();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h12345678;
    ref_mem[32'h40] = 32'h12345678;
    d_exp.push_back(last_d_rd);
    tick();
    d_wdata = '0; d_addr = 32'h44; d_we = 1'b0;
    #1;
    chk1("t3_mem_we", mem_we, 1'b1);
    check("t3_mem_addr", mem_addr, 32'h40);
    check("t3_mem_wdata", mem_wdata, 32'h12345678);
    tick();
    chk1("t3_d_valid", d_valid, 1'b1);
    d_req = 1'b0;
    check("t3_mem_written", resp_rd(32'h40), 32'h12345678);
    tick();
    chk1("t3_d_valid_once", d_valid, 1'b0);

    // Asynchronous reset one cycle before the acknowledge.
    fixed_wait = 2;
    tick();
    i_req = 1'b1; i_addr = 32'h14;
    tick();
    tick();
    #1;
    reset = 1'b0;
    mem_ack = 1'b0;
    #1;
    chk1("t4_mem_req", mem_req, 1'b0);
    chk1("t4_busy", busy, 1'b0);
    check("t4_mem_addr", mem_addr, '0);
    check("t4_i_rdata", i_rdata, '0);
    check("t4_d_rdata", d_rdata, '0);
    last_d_rd = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk1("t4_no_valid", i_valid, 1'b0);
    end
    i_addr = 32'h18;
    i_exp.push_back(ref_rd(32'h18));
    reset = 1'b1;
    wait_valid(1'b0, ok);
    i_req = 1'b0;
    tick();

    // Random concurrent traffic with random memory latency.
    fixed_wait = -1;
    fork
      if_driver(40);
      d_driver(40);
    join
    repeat (4) tick();
    check("i_queue_drained", 32'(i_exp.size()), '0);
    check("d_queue_drained", 32'(d_exp.size()), '0);

    // Both requesters held continuously: grant order.
    fixed_wait = 0;
    tick();
    i_req = 1'b1; i_addr = 32'h08;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h208;
    i_exp.push_back(ref_rd(32'h08));
    last_d_rd = ref_rd(32'h208);
    d_exp.push_back(last_d_rd);
    grants = 0;
    tmo = 0;
    while ((i_req || d_req) && tmo < 400) begin
      tick();
      tmo++;
      if (d_valid || i_valid) begin
        is_d = d_valid;
        if (grants < 10) begin
          chk1("grant_order", is_d, exp_grant_d(grants));
          grants++;
        end
        keep = (grants < 10);
        if (is_d) begin
          if (keep) d_exp.push_back(ref_rd(32'h208));
          else d_req = 1'b0;
        end else begin
          if (keep) i_exp.push_back(ref_rd(32'h08));
          else i_req = 1'b0;
        end
      end
    end
    if (tmo >= 400) report("grant_order_timeout");
    i_req = 1'b0;
    d_req = 1'b0;
    repeat (3) tick();
    check("final_i_drained", 32'(i_exp.size()), '0);
    check("final_d_drained", 32'(d_exp.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the instruction-fetch (IF) requester and the data-access (MEM) requester of the pipelined CPU.
- Sequences each transaction over a variable-latency memory handshake.
- Returns read data to the winning requester.
- Produces stall signals so the pipeline freezes while its request is outstanding.

Parameters:
- ADDR_W, 32, address width in bits
- DATA_W, 32, data width in bits
- STARVE_LIMIT, 4, maximum consecutive data grants while IF waits (used only with the optional feature)

Ports:
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low reset
- i_req  in  1  IF read request; held high with i_addr stable until i_valid
- i_addr  in  ADDR_W  IF address
- i_rdata  out  DATA_W  IF read data, valid when i_valid=1
- i_valid  out  1  one-cycle completion pulse to IF
- i_stall  out  1  i_req & ~i_valid (combinational)
- d_req  in  1  MEM request; held with d_we/d_addr/d_wdata stable until d_valid
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data, valid when d_valid=1
- d_valid  out  1  one-cycle completion pulse to MEM
- d_stall  out  1  d_req & ~d_valid (combinational)
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_ack  in  1  memory completion, one cycle; mem_rdata valid in the same cycle
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  state != IDLE

Behaviour:
- FSM states: IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D.
- IDLE:
  - d_req=1 -> latch d_we/d_addr/d_wdata, go BUSY_D.
  - else i_req=1 -> latch i_addr, go BUSY_I.
  - Data wins ties: strict priority, the older instruction goes first.
- BUSY_x:
  - mem_req=1; mem_addr/mem_we/mem_wdata come from the latched registers, never from live inputs.
  - mem_we=0 in BUSY_I.
  - On mem_ack: capture mem_rdata into x_rdata and go DONE_x; otherwise remain.
- DONE_x:
  - x_valid=1 for exactly this cycle; return to IDLE.
  - Requests are not sampled in DONE, so a held-high req after valid is treated as a new request in IDLE.
- Latency:
  - Request seen in IDLE at cycle 0 -> mem_req high in cycle 1.
  - mem_ack in cycle 1+k (k>=0) -> valid in cycle 2+k.
  - Minimum latency is 2 cycles from IDLE sample to valid.
- d_rdata for writes: holds the previous value. i_rdata/d_rdata hold between transactions.
- mem_ack outside BUSY_x is ignored.
- Inputs changing during BUSY_x are ignored because the request is already latched.
- Dropping req mid-transaction does not abort it: the memory transaction completes, valid still pulses, and the requester ignores it.
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - i_valid=0, d_valid=0, i_rdata=0, d_rdata=0, busy=0.
  - Starvation counter=0.
  - Reset mid-transaction discards the transaction with no valid pulse. The memory side sees mem_req drop and must tolerate it.
- Release is synchronous-safe: the first arbitration happens on the first rising edge with reset=1.

Optional Feature:
- Macro: MEM_ARB_FAIRNESS_EN.
- Defined:
  - A 3-bit-min counter (width clog2(STARVE_LIMIT+1)) increments on each data grant made while i_req=1.
  - It clears on any IF grant, or in IDLE when i_req=0.
  - When counter==STARVE_LIMIT and both requests are pending in IDLE, IF wins that arbitration.
- Undefined: strict data priority; the counter logic is absent.

Test Plan:
- Single fetch, i_addr=0x10, memory acks after 3 wait cycles with 0xDEADBEEF -> mem_req high cycles 1-4, i_valid pulse cycle 5, i_rdata=0xDEADBEEF, d_valid never asserts.
- Simultaneous i_req (0x20) and d_req read (0x100), zero-wait memory -> data served first (d_valid cycle 2), fetch next (mem_addr=0x20 in cycle 4, i_valid cycle 5); i_stall high cycles 0-4.
- Store d_we=1, d_addr=0x40, d_wdata=0x12345678; drive d_wdata=0 during BUSY_D -> mem_wdata stays 0x12345678, mem_we=1, d_valid once, d_rdata unchanged.
- reset pulled low in BUSY_I, 1 cycle before mem_ack -> outputs zero immediately (asynchronous), no i_valid; after release, a new i_req completes normally.
- MEM_ARB_FAIRNESS_EN with STARVE_LIMIT=4, d_req and i_req held continuously -> grant order D,D,D,D,I,D,D,D,D,I; without the macro, IF is never granted while d_req=1.
